// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128/192/256 inverse cipher: one decryption round per clock from pre-expanded round keys.
// Build macro AES_DEC_KEY_REG_EN adds an internal round-key register captured by kld while idle.

package aes_dec_pkg;
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // GF(2^8) inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq, r;
      sq = gmul(x, x);
      r  = sq;
      for (int i = 0; i < 6; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   // inverse affine transform followed by field inversion
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] a;
      a = 8'h00;
      for (int i = 0; i < 8; i++) a[i] = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8];
      return gf_inv(a ^ 8'h05);
   endfunction
endpackage

module inv_subbytes_128
   import aes_dec_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);
   for (genvar g = 0; g < 16; g++) begin : g_byte
      assign dout[8*g +: 8] = inv_sbox(din[8*g +: 8]);
   end
endmodule

module aes_decrypt_iterative
   import aes_dec_pkg::*;
#(
   parameter  int NR    = 10,
   localparam int KEY_W = 128*(NR+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             kld,
   input  logic [0:KEY_W-1] round_keys,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             busy
);
   localparam int RW = $clog2(NR);

   if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
      $error("aes_decrypt_iterative: NR must be 10, 12 or 14");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic [RW-1:0]    rnd_q, rnd_d;
   logic [127:0]     st_q, st_d;
   logic [127:0]     od_q, od_d;
   logic             ov_q, ov_d;
   logic [0:KEY_W-1] keys;
   logic [127:0]     rk_rnd, rk_last, isr, isb, ark, rnd_out;

   // byte k of the state sits at bits [127-8k -: 8]; row = k%4, column = k/4
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

`ifdef AES_DEC_KEY_REG_EN
   logic [0:KEY_W-1] key_q, key_d;
   logic             key_ok_q, key_ok_d;

   always_comb begin
      key_d    = key_q;
      key_ok_d = key_ok_q;
      if (fsm_q == IDLE && kld) begin
         key_d    = round_keys;
         key_ok_d = 1'b1;
      end
   end

   // key storage is deliberately not reset; only the valid flag is
   always_ff @(posedge clk) key_q <= key_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) key_ok_q <= 1'b0;
      else       key_ok_q <= key_ok_d;
   end

   assign keys     = key_q;
   assign in_ready = (fsm_q == IDLE) && key_ok_q && !kld;
`else
   logic unused_kld;
   assign unused_kld = kld;
   assign keys       = round_keys;
   assign in_ready   = (fsm_q == IDLE);
`endif

   assign rk_last = keys[128*NR +: 128];
   assign rk_rnd  = keys[128*int'(rnd_q) +: 128];
   assign isr     = inv_shift_rows(st_q);

   inv_subbytes_128 u_isb (.din(isr), .dout(isb));

   assign ark     = isb ^ rk_rnd;
   assign rnd_out = (rnd_q == '0) ? ark : inv_mix_columns(ark);

   always_comb begin
      fsm_d = fsm_q;
      rnd_d = rnd_q;
      st_d  = st_q;
      od_d  = od_q;
      ov_d  = ov_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               st_d  = in_data ^ rk_last;
               rnd_d = RW'(NR-1);
               fsm_d = ROUND;
            end
         end
         ROUND: begin
            st_d = rnd_out;
            if (rnd_q == '0) begin
               od_d  = rnd_out;
               ov_d  = 1'b1;
               fsm_d = DONE;
            end else begin
               rnd_d = rnd_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_d  = 1'b0;
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q <= IDLE;
         rnd_q <= '0;
         st_q  <= '0;
         od_q  <= '0;
         ov_q  <= 1'b0;
      end else begin
         fsm_q <= fsm_d;
         rnd_q <= rnd_d;
         st_q  <= st_d;
         od_q  <= od_d;
         ov_q  <= ov_d;
      end
   end

   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign busy      = (fsm_q != IDLE);
endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for aes_decrypt_iterative: FIPS-197 vectors, stalls, mid-op reset and random blocks
// checked against a forward-cipher reference model (NR = 10, 12, 14 instances).
module tb_aes_decrypt_iterative;
   logic         clk = 1'b0;
   logic         reset, kld;
   logic [127:0] in_data;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic         busy      [3];
   logic [127:0] out_data  [3];
   logic [0:1919] rkb      [3];

   int nvec = 0;
   int nerr = 0;
   logic [7:0] sbox [256];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_decrypt_iterative #(.NR(10 + 2*g)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .kld        (kld),
         .round_keys (rkb[g][0:128*(11+2*g)-1]),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .in_data    (in_data),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .out_data   (out_data[g]),
         .busy       (busy[g])
      );
   end

`ifdef AES_DEC_KEY_REG_EN
   localparam bit KEYREG = 1'b1;
`else
   localparam bit KEYREG = 1'b0;
`endif

   typedef struct {
      int           k;
      logic [255:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      int           stall;
   } vec_t;

   localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
   localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   // FIPS-197 key schedule, words laid out with round key i at bits [128*i +: 128]
   function automatic logic [0:1919] expand(input int nr, input logic [255:0] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:1919] r;
      int            nk;
      nk = nr - 6;
      rc = 8'h01;
      r  = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < 4*(nr+1); i++) r[32*i +: 32] = w[i];
      return r;
   endfunction

   // forward cipher: the DUT must invert this
   function automatic logic [127:0] encrypt(input int nr, input logic [0:1919] rk, input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ rk[8*j +: 8];
      for (int rn = 1; rn <= nr; rn++) begin
         for (int j = 0; j < 16; j++) t[j] = sbox[s[j]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
         if (rn < nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[128*rn + 8*j +: 8];
      end
      o = '0;
      for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic load_key(input int k, input logic [255:0] key);
      rkb[k] = expand(10 + 2*k, key);
      if (KEYREG) begin
         kld = 1'b1;
         @(negedge clk);
         kld = 1'b0;
      end
   endtask

   // called at a negedge; leaves at a negedge with the block handed off
   task automatic run_block(input int k, input logic [127:0] ct, input logic [127:0] pt,
                            input int stall, input string nm);
      int   n, w;
      logic ok;
      out_ready[k] = (stall == 0);
      in_valid[k]  = 1'b1;
      in_data      = ct;
      w = 0;
      while (!in_ready[k] && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready[k]) begin
         nvec++;
         nerr++;
         $display("FAIL %s_accept: in_ready stuck at 0, want 1", nm);
         in_valid[k] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid[k] = 1'b0;
      in_data     = rnd128();
      n = 0;
      while (!out_valid[k] && n < 60) begin
         kld = 1'($urandom);
         @(negedge clk);
         n++;
      end
      kld = 1'b0;
      chk({nm, "_lat"}, 128'(n), 128'(10 + 2*k));
      chk({nm, "_data"}, out_data[k], pt);
      if (stall > 0) begin
         ok = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!out_valid[k] || in_ready[k] || !busy[k] || out_data[k] !== pt) ok = 1'b0;
         end
         chk({nm, "_hold"}, 128'(ok), 128'(1));
         out_ready[k] = 1'b1;
      end
      @(negedge clk);
      chk({nm, "_release"}, 128'({out_valid[k], busy[k]}), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl [5];
      logic [7:0]   p, q, x;
      logic [255:0] key;
      logic [127:0] pt, ct;
      logic         ok;
      int           n;

      // S-box from the generator/affine construction
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;

      tbl[0] = '{0, K128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 0};
      tbl[1] = '{1, K192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, 0};
      tbl[2] = '{2, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, 0};
      tbl[3] = '{0, K128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 20};
      tbl[4] = '{2, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, 5};

      reset   = 1'b1;
      kld     = 1'b0;
      in_data = '0;
      for (int g = 0; g < 3; g++) begin
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b0;
         rkb[g]       = '0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_outs%0d", g), 128'({out_valid[g], busy[g]}), 128'(0));
         chk($sformatf("rst_data%0d", g), out_data[g], 128'h0);
         chk($sformatf("rst_in_ready%0d", g), 128'(in_ready[g]), 128'(!KEYREG));
      end

`ifdef AES_DEC_KEY_REG_EN
      // no key yet: block must wait; kld with in_valid loads first, accepts next cycle
      in_valid[0] = 1'b1;
      in_data     = tbl[0].ct;
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (in_ready[0] || busy[0]) ok = 1'b0;
      end
      chk("nokey_block", 128'(ok), 128'(1));
      rkb[0] = expand(10, K128);
      kld = 1'b1;
      #1;
      chk("kld_same_cycle", 128'(in_ready[0]), 128'(0));
      @(negedge clk);
      kld = 1'b0;
      #1;
      chk("kld_then_ready", 128'(in_ready[0]), 128'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      rkb[0]       = {15{rnd128()}};
      n = 0;
      while (!out_valid[0] && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("keyreg_lat", 128'(n), 128'(10));
      chk("keyreg_data", out_data[0], PT);
      @(negedge clk);
`endif

      for (int i = 0; i < 5; i++) begin
         load_key(tbl[i].k, tbl[i].key);
         run_block(tbl[i].k, tbl[i].ct, tbl[i].pt, tbl[i].stall, $sformatf("kat%0d", i));
      end

      // reset while rnd==4: the block must vanish
      load_key(0, K128);
      chk("midop_accept", 128'(in_ready[0]), 128'(1));
      in_valid[0]  = 1'b1;
      in_data      = tbl[0].ct;
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ok = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (out_valid[0] || busy[0]) ok = 1'b0;
      end
      chk("midop_no_output", 128'(ok), 128'(1));
      chk("midop_data_clear", out_data[0], 128'h0);

      // 100 back-to-back random blocks on NR=10
      for (int kk = 0; kk < 10; kk++) begin
         key = {rnd128(), 128'h0};
         load_key(0, key);
         for (int b = 0; b < 10; b++) begin
            pt = rnd128();
            ct = encrypt(10, rkb[0], pt);
            run_block(0, ct, pt, 0, "rnd10");
         end
      end

      for (int k = 1; k < 3; k++) begin
         for (int b = 0; b < 8; b++) begin
            key = {rnd128(), rnd128()};
            load_key(k, key);
            pt = rnd128();
            ct = encrypt(10 + 2*k, rkb[k], pt);
            run_block(k, ct, pt, int'($urandom_range(0, 3)), $sformatf("rnd%0d", 10 + 2*k));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
